// File: rtl/fifo_wr_serializer.sv
// Wide-to-narrow write serializer feeding the async FIFO write port, LSB beat first.
// Optional WR_SER_STALL_CNT_EN adds a saturating backpressure counter output stall_cnt.
module fifo_wr_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                        wclk,
  input  logic                        wrst,
  input  logic                        s_valid,
  input  logic [RATIO*DATA_WIDTH-1:0] s_data,
  output logic                        s_ready,
  output logic                        m_valid,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic                        busy
`ifdef WR_SER_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WORD_W = RATIO * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                cnt_last;
  logic                s_fire;
  logic                m_fire;
  logic                last_fire;

  always_comb begin
    m_valid   = (state_q == SEND);
    cnt_last  = (cnt_q == LAST_CNT);
    m_fire    = m_valid && m_ready;
    last_fire = m_fire && cnt_last;
    s_ready   = (state_q == IDLE) || last_fire;
    s_fire    = s_valid && s_ready;
    m_last    = m_valid && cnt_last;
    busy      = m_valid;
  end

  // Explicit beat mux keeps every slice in range for non-power-of-two RATIO.
  always_comb begin
    m_data = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        m_data = word_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (s_fire) begin
          word_d  = s_data;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_fire) begin
          if (s_fire) begin
            word_d = s_data;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (m_fire) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WR_SER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !m_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
`ifdef WR_SER_STALL_CNT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
`ifdef WR_SER_STALL_CNT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_serializer.sv
// Bench for fifo_wr_serializer: vector table plus beat scoreboard, RATIO=4 and RATIO=3 instances.
module tb_fifo_wr_serializer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int R3 = 3;
  localparam int NV = 5;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  logic            s_valid = 1'b0;
  logic [R*DW-1:0] s_data  = '0;
  logic            s_ready;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic            m_ready = 1'b0;
  logic            busy;

  logic             s3_valid = 1'b0;
  logic [R3*DW-1:0] s3_data  = '0;
  logic             s3_ready;
  logic             m3_valid;
  logic [DW-1:0]    m3_data;
  logic             m3_last;
  logic             m3_ready = 1'b0;
  logic             busy3;

`ifdef WR_SER_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] stall_cnt3;
`endif

  fifo_wr_serializer #(.DATA_WIDTH(DW), .RATIO(R)) u_dut (
    .wclk(wclk), .wrst(wrst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy)
`ifdef WR_SER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  fifo_wr_serializer #(.DATA_WIDTH(DW), .RATIO(R3)) u_dut3 (
    .wclk(wclk), .wrst(wrst),
    .s_valid(s3_valid), .s_data(s3_data), .s_ready(s3_ready),
    .m_valid(m3_valid), .m_data(m3_data), .m_last(m3_last), .m_ready(m3_ready),
    .busy(busy3)
`ifdef WR_SER_STALL_CNT_EN
    , .stall_cnt(stall_cnt3)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  // Scoreboard: beats pushed on word acceptance, popped on every beat handshake.
  always @(negedge wclk) begin
    beat_t eb;
    logic [R*DW-1:0] w;
    if (wrst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(m_valid), 64'(1));
        chk("hold_data", 64'(m_data), 64'(prev_data));
        chk("hold_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
        chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          eb = sb.pop_front();
          chk("beat_data", 64'(m_data), 64'(eb.data));
          chk("beat_last", 64'(m_last), 64'(eb.last));
        end
      end
      if (s_valid && s_ready) begin
        w = s_data;
        for (int i = 0; i < R; i++) begin
          eb.data = w[i*DW +: DW];
          eb.last = (i == R - 1);
          sb.push_back(eb);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  typedef struct {
    logic [R*DW-1:0] word;
    logic [7:0]      ready_pat;
    int              exp_cycles;
    int              exp_stalls;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    int cyc;
    int fired;
    int nacc;
    int nvalid;
    int first_v;
    int last_v;
    int nb;
    logic [DW-1:0]    exp_single[4];
    logic [R3*DW-1:0] w3[2];
    logic [DW-1:0]    exp3[6];
`ifdef WR_SER_STALL_CNT_EN
    logic [15:0] st0;
`endif

    vecs[0] = '{32'hDDCCBBAA, 8'hFF, 4, 0};
    vecs[1] = '{32'hA1B2C3D4, 8'hE9, 7, 3};
    vecs[2] = '{32'hFEEDBEEF, 8'hAA, 8, 4};
    vecs[3] = '{32'h00FF00FF, 8'h0F, 4, 0};
    vecs[4] = '{32'h5A5AA5A5, 8'hF0, 8, 4};
    exp_single = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    // Reset state
    repeat (3) @(posedge wclk);
    #1 wrst = 1'b0;
    @(negedge wclk);
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(1));
`ifdef WR_SER_STALL_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif

    // Single word, zero backpressure
    @(posedge wclk); #1;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDDCCBBAA;
    @(posedge wclk); #1;
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge wclk);
      chk("single_valid", 64'(m_valid), 64'(1));
      chk("single_data", 64'(m_data), 64'(exp_single[i]));
      chk("single_last", 64'(m_last), 64'(i == 3));
      chk("single_s_ready", 64'(s_ready), 64'(i == 3));
      @(posedge wclk); #1;
    end
    @(negedge wclk);
    chk("single_idle_valid", 64'(m_valid), 64'(0));
    chk("single_idle_ready", 64'(s_ready), 64'(1));
    @(posedge wclk); #1;

    // Table-driven words with per-cycle m_ready patterns
    for (int v = 0; v < NV; v++) begin
      cyc = 0;
      while (!s_ready && cyc < 20) begin
        @(posedge wclk); #1;
        cyc++;
      end
      chk("vec_s_ready", 64'(s_ready), 64'(1));
`ifdef WR_SER_STALL_CNT_EN
      st0 = stall_cnt;
`endif
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = vecs[v].word;
      @(posedge wclk); #1;
      s_valid = 1'b0;
      cyc   = 0;
      fired = 0;
      while (fired < R && cyc < 50) begin
        m_ready = vecs[v].ready_pat[cyc % 8];
        @(negedge wclk);
        if (cyc == 0) chk("vec_first_valid", 64'(m_valid), 64'(1));
        if (m_valid && m_ready) fired++;
        @(posedge wclk); #1;
        cyc++;
      end
      m_ready = 1'b0;
      chk("vec_cycles", 64'(cyc), 64'(vecs[v].exp_cycles));
      chk("vec_busy_after", 64'(busy), 64'(0));
`ifdef WR_SER_STALL_CNT_EN
      chk("vec_stalls", 64'(stall_cnt - st0), 64'(vecs[v].exp_stalls));
`endif
    end

    // Back-to-back words with s_valid held
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h03020100;
    nacc = 0; nvalid = 0; first_v = -1; last_v = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge wclk);
      if (s_valid && s_ready) begin
        if (nacc == 1) begin
          chk("b2b_accept_beat", 64'(m_data), 64'(8'h03));
          chk("b2b_accept_last", 64'(m_last), 64'(1));
        end
        nacc++;
      end
      if (m_valid) begin
        nvalid++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      @(posedge wclk); #1;
      if (nacc == 1) s_data = 32'h07060504;
      else if (nacc >= 2) s_valid = 1'b0;
    end
    chk("b2b_accepts", 64'(nacc), 64'(2));
    chk("b2b_valid_cycles", 64'(nvalid), 64'(8));
    chk("b2b_no_gap", 64'(last_v - first_v + 1), 64'(8));

    // Reset in the middle of a word
    s_valid = 1'b1;
    s_data  = 32'h44332211;
    @(posedge wclk); #1;
    s_valid = 1'b0;
    fired = 0; cyc = 0;
    while (fired < 2 && cyc < 10) begin
      @(negedge wclk);
      if (m_valid && m_ready) fired++;
      @(posedge wclk); #1;
      cyc++;
    end
    chk("midrst_two_beats", 64'(fired), 64'(2));
    wrst = 1'b1;
    #1;
    chk("midrst_valid_drop", 64'(m_valid), 64'(0));
    chk("midrst_busy_drop", 64'(busy), 64'(0));
    @(posedge wclk);
    @(posedge wclk); #1;
    wrst = 1'b0;
    @(negedge wclk);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_s_ready", 64'(s_ready), 64'(1));
`ifdef WR_SER_STALL_CNT_EN
    chk("midrst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    @(posedge wclk); #1;
    s_valid = 1'b1;
    s_data  = 32'h88776655;
    @(posedge wclk); #1;
    s_valid = 1'b0;
    fired = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge wclk);
      if (m_valid && m_ready) fired++;
      @(posedge wclk); #1;
    end
    chk("midrst_next_beats", 64'(fired), 64'(4));

`ifdef WR_SER_STALL_CNT_EN
    // Stall counter saturation
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hCAFEF00D;
    @(posedge wclk); #1;
    s_valid = 1'b0;
    repeat (65540) @(posedge wclk);
    #1;
    chk("sat_stall_cnt", 64'(stall_cnt), 64'(16'hFFFF));
    chk("sat_still_valid", 64'(m_valid), 64'(1));
    m_ready = 1'b1;
    fired = 0; cyc = 0;
    while (fired < R && cyc < 10) begin
      @(negedge wclk);
      if (m_valid && m_ready) fired++;
      @(posedge wclk); #1;
      cyc++;
    end
    chk("sat_drain_beats", 64'(fired), 64'(4));
    chk("sat_stall_hold", 64'(stall_cnt), 64'(16'hFFFF));
`endif

    // RATIO=3 instance, second word reloaded on the last beat
    w3[0] = 24'hCCBBAA;
    w3[1] = 24'h332211;
    for (int wi = 0; wi < 2; wi++)
      for (int i = 0; i < R3; i++)
        exp3[wi*R3 + i] = w3[wi][i*DW +: DW];
    m3_ready = 1'b1;
    s3_valid = 1'b1;
    s3_data  = w3[0];
    nacc = 0; nb = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge wclk);
      if (m3_valid && m3_ready) begin
        if (nb < 6) begin
          chk("r3_data", 64'(m3_data), 64'(exp3[nb]));
          chk("r3_last", 64'(m3_last), 64'((nb % 3) == 2));
        end
        nb++;
      end
      if (s3_valid && s3_ready) nacc++;
      @(posedge wclk); #1;
      if (nacc == 1) s3_data = w3[1];
      else if (nacc >= 2) s3_valid = 1'b0;
    end
    chk("r3_beats", 64'(nb), 64'(6));
    chk("r3_accepts", 64'(nacc), 64'(2));
    chk("r3_idle", 64'(busy3), 64'(0));

    @(negedge wclk);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_serializer.md
# fifo_wr_serializer

Write-domain width converter that feeds the write port of the team's asynchronous FIFO. It accepts one wide word of RATIO×DATA_WIDTH bits over a valid/ready handshake and emits it as RATIO narrow beats on a second valid/ready interface. That interface connects directly to the FIFO's w_valid / w_data / w_ready. The block runs entirely in the wclk domain, sustains one beat per cycle under zero backpressure, and inserts no bubbles between consecutive words.

## Interface
- DATA_WIDTH, 8, width of one output beat; must equal the FIFO DATA_WIDTH.
- RATIO, 4, beats per input word; ≥2, power of two not required.
- wclk  input  1  write-domain clock; all state updates on its rising edge.
- wrst  input  1  reset, asynchronous, active-high.
- s_valid  input  1  upstream word valid.
- s_data  input  RATIO*DATA_WIDTH  upstream word.
- s_ready  output  1  block can accept a word this cycle.
- m_valid  output  1  beat valid; connects to FIFO w_valid.
- m_data  output  DATA_WIDTH  beat data; connects to FIFO w_data.
- m_last  output  1  high on the final beat of a word.
- m_ready  input  1  downstream accepts the beat; connects to FIFO w_ready.
- busy  output  1  a word is held, i.e. state is SEND.
- stall_cnt  output  16  saturating backpressure counter; exists only with WR_SER_STALL_CNT_EN.

## Operation
- Two-state FSM: IDLE and SEND. Holding register word_q is RATIO*DATA_WIDTH wide. Beat counter cnt is $clog2(RATIO) bits.
- Handshake definitions:
  - s_fire = s_valid && s_ready.
  - m_fire = m_valid && m_ready.
  - last_fire = m_fire && cnt == RATIO-1.
- s_ready (combinational) = (state == IDLE) || last_fire.
- IDLE:
  - On s_fire: word_q ← s_data, cnt ← 0, go to SEND.
  - Otherwise hold.
- SEND:
  - On m_fire with cnt < RATIO-1: cnt ← cnt+1.
  - On last_fire with s_fire in the same cycle: load the new word, cnt ← 0, stay in SEND.
  - On last_fire without s_fire: go to IDLE.
  - With no m_fire: hold all state.
- Beat ordering is LSB first: m_data = word_q[cnt*DATA_WIDTH +: DATA_WIDTH].
- m_valid = (state == SEND). m_last = m_valid && cnt == RATIO-1. busy = m_valid.
- While m_valid && !m_ready, m_valid, m_data and m_last stay stable.
- m_valid never depends combinationally on m_ready.
- s_data is sampled only on s_fire. While s_ready is low, s_data is ignored.

## Timing
- Reset values:
  - state = IDLE, cnt = 0, word_q = 0.
  - m_valid = 0, m_last = 0, m_data = 0, busy = 0.
  - s_ready = 1 after reset deassertion.
  - stall_cnt = 0.
- Latency: a word accepted at edge k presents beat 0 in the cycle after edge k.
- With m_ready held high, the last beat goes out at edge k+RATIO.
- Throughput: continuous s_valid plus continuous m_ready gives exactly one beat per wclk and 100% m_valid duty.
- Backpressure: each m_ready=0 cycle delays every later beat by one cycle. No beat is dropped or duplicated.
- Reset mid-word: wrst assertion immediately drops m_valid and discards word_q and all remaining beats. There is no partial-word recovery.
- Upstream must not drive s_valid while wrst is high.
- cnt wraps only via reload to 0. It never increments past RATIO-1.

## Configuration
- WR_SER_STALL_CNT_EN defined:
  - Adds the 16-bit output stall_cnt.
  - stall_cnt increments on every wclk where m_valid && !m_ready.
  - Saturates at 16'hFFFF; cleared only by wrst.
- WR_SER_STALL_CNT_EN undefined:
  - Port stall_cnt and its register are absent.
  - All other behaviour is identical.

## Test plan
- Single word: DATA_WIDTH=8, RATIO=4, s_data=32'hDDCCBBAA, m_ready=1 → beats AA, BB, CC, DD on four consecutive cycles; m_last only with DD; s_ready low for three cycles, then high.
- Back-to-back: words 32'h03020100 then 32'h07060504 with s_valid held and m_ready=1 → beats 00..07 on eight consecutive cycles with no gap; second word accepted in the same cycle as beat 03.
- Backpressure: m_ready toggled 1,0,0,1,0,1,1 during one word → each beat held stable while stalled; exactly four beats out; with the macro defined, stall_cnt = 3.
- Reset mid-word: assert wrst after beat 1 of 32'h44332211 → m_valid drops immediately; after release, busy = 0, s_ready = 1; next word 32'h88776655 emits 55, 66, 77, 88 only.
- Stall saturation (macro defined): m_valid held with m_ready = 0 for 70000 cycles → stall_cnt = 16'hFFFF, with no wrap.
- Non-power-of-two: RATIO=3, s_data=24'hCCBBAA → beats AA, BB, CC; m_last on CC; cnt returns to 0 on reload.
